// File: rtl/axi4_mem_slave_if.sv
// axi4_mem_slave_if: AXI4 bus bundle between a memory master and axi4_mem_slave.
// Parameters: DATA_WIDTH (data bus bits), ADDR_WIDTH (byte address bits).
// Channels: AW/W/B (write address, data, response) and AR/R (read address, data).
// Modports: master drives AW/W/AR payloads, BREADY and RREADY.
//           slave drives the AWREADY/WREADY/ARREADY handshakes and the B/R responses.
interface axi4_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RLAST;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID, RLAST,
        input  RREADY
    );

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID, RLAST,
        output RREADY
    );
endinterface

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: parametrised AXI4 memory slave with independent read and write engines.
// Ports: ACLK (rising-edge clock), ARESET (synchronous active-high reset),
//        bus (axi4_mem_slave_if.slave: AW/W/B write channels, AR/R read channels).
// Parameters: DATA_WIDTH (32/64/128), ADDR_WIDTH (byte address bits), MEM_DEPTH (words).
// Build option: define AXI4_MEM_WRAP_BURST_EN to support WRAP bursts; otherwise
// AxBURST==2 is answered with SLVERR on every beat and no wrap logic exists.
module axi4_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input logic              ACLK,
    input logic              ARESET,
    axi4_mem_slave_if.slave  bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OFFS = $clog2(NB);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);
    localparam logic [1:0] OKAY = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a >> OFFS) >= DEPTH_U;
    endfunction

    wstate_t               w_state_q;
    logic [ADDR_WIDTH-1:0] waddr_q, w_inc, w_nxt;
    logic [7:0]            wlen_q, wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q, bresp_q;
    logic                  werr_q, awready_q, wready_q, bvalid_q;
    logic                  w_cfg_bad, w_bad, w_we;
`ifdef AXI4_MEM_WRAP_BURST_EN
    logic [ADDR_WIDTH-1:0] w_mask;
`endif

    // Burst-level legality is re-derived from the latched descriptor every beat;
    // a wrapping address keeps its sub-size bits, so the alignment test stays valid.
    always_comb begin
        w_inc = waddr_q + (ADDR_WIDTH'(1) << wsize_q);
`ifdef AXI4_MEM_WRAP_BURST_EN
        w_mask = ((ADDR_WIDTH'(wlen_q) + ADDR_WIDTH'(1)) << wsize_q) - ADDR_WIDTH'(1);
        w_nxt = wburst_q == 2'd0 ? waddr_q : wburst_q == 2'd2 ? (waddr_q & ~w_mask) | (w_inc & w_mask) : w_inc;
        w_cfg_bad = wsize_q > 3'(OFFS) || wburst_q == 2'd3 || (wburst_q == 2'd2 &&
            (!(wlen_q inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
             (waddr_q & ((ADDR_WIDTH'(1) << wsize_q) - ADDR_WIDTH'(1))) != '0));
`else
        w_nxt = wburst_q == 2'd0 ? waddr_q : w_inc;
        w_cfg_bad = wsize_q > 3'(OFFS) || wburst_q[1];
`endif
        w_bad = w_cfg_bad || oor(waddr_q);
        w_we = w_state_q == W_DATA && bus.WVALID && !w_bad && !ARESET;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (bus.AWVALID && awready_q) begin
                        waddr_q   <= bus.AWADDR;
                        wlen_q    <= bus.AWLEN;
                        wsize_q   <= bus.AWSIZE;
                        wburst_q  <= bus.AWBURST;
                        wcnt_q    <= 8'd0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.WVALID) begin
                        waddr_q <= w_nxt;
                        wcnt_q  <= wcnt_q + 8'd1;
                        // The beat count, not WLAST, ends the burst; a WLAST mismatch only taints BRESP.
                        if (wcnt_q == wlen_q) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (werr_q || w_bad || !bus.WLAST) ? SLVERR : OKAY;
                            w_state_q <= W_RESP;
                        end else if (w_bad || bus.WLAST) begin
                            werr_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= OKAY;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_we)
            for (int b = 0; b < NB; b++)
                if (bus.WSTRB[b])
                    mem[waddr_q[OFFS +: IW]][8*b +: 8] <= bus.WDATA[8*b +: 8];
    end

    rstate_t               r_state_q;
    logic [ADDR_WIDTH-1:0] raddr_q, ra, r_inc, r_nxt;
    logic [7:0]            rlen_q, rcnt_q;
    logic [2:0]            rsize_q, rs;
    logic [1:0]            rburst_q, rb, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q, r_word;
    logic                  arready_q, rvalid_q, rlast_q, r_cfg_bad, r_bad;
`ifdef AXI4_MEM_WRAP_BURST_EN
    logic [ADDR_WIDTH-1:0] r_mask;
    logic [7:0]            rl;
`endif

    // In idle the beat being fetched is beat 0 of the incoming AR; afterwards raddr_q
    // already points at the next beat, so one fetch path serves both cases.
    always_comb begin
        ra = r_state_q == R_IDLE ? bus.ARADDR : raddr_q;
        rs = r_state_q == R_IDLE ? bus.ARSIZE : rsize_q;
        rb = r_state_q == R_IDLE ? bus.ARBURST : rburst_q;
        r_inc = ra + (ADDR_WIDTH'(1) << rs);
`ifdef AXI4_MEM_WRAP_BURST_EN
        rl = r_state_q == R_IDLE ? bus.ARLEN : rlen_q;
        r_mask = ((ADDR_WIDTH'(rl) + ADDR_WIDTH'(1)) << rs) - ADDR_WIDTH'(1);
        r_nxt = rb == 2'd0 ? ra : rb == 2'd2 ? (ra & ~r_mask) | (r_inc & r_mask) : r_inc;
        r_cfg_bad = rs > 3'(OFFS) || rb == 2'd3 || (rb == 2'd2 &&
            (!(rl inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
             (ra & ((ADDR_WIDTH'(1) << rs) - ADDR_WIDTH'(1))) != '0));
`else
        r_nxt = rb == 2'd0 ? ra : r_inc;
        r_cfg_bad = rs > 3'(OFFS) || rb[1];
`endif
        r_bad = r_cfg_bad || oor(ra);
        r_word = mem[ra[OFFS +: IW]];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (bus.ARVALID && arready_q) begin
                        rdata_q   <= r_bad ? '0 : r_word;
                        rresp_q   <= r_bad ? SLVERR : OKAY;
                        rlast_q   <= bus.ARLEN == 8'd0;
                        rlen_q    <= bus.ARLEN;
                        rsize_q   <= bus.ARSIZE;
                        rburst_q  <= bus.ARBURST;
                        rcnt_q    <= 8'd0;
                        raddr_q   <= r_nxt;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                default: begin
                    if (bus.RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rdata_q <= r_bad ? '0 : r_word;
                            rresp_q <= r_bad ? SLVERR : OKAY;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rlast_q <= rcnt_q + 8'd1 == rlen_q;
                            raddr_q <= r_nxt;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RLAST   = rlast_q;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: scoreboard bench for axi4_mem_slave with directed bursts.
module tb_axi4_mem_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    logic [34:0] rq[$];
    logic [1:0]  bq[$];

    axi4_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();
    axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024)) dut (
        .ACLK(clk), .ARESET(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired or unexpected response", name);
    endtask

    always @(negedge clk) begin
        if (bus.RVALID) begin
            if (rq.size() == 0) fail("r_unexpected");
            else if (bus.RREADY) chk("r_beat", {bus.RDATA, bus.RRESP, bus.RLAST}, rq.pop_front());
            else chk("r_stall", {bus.RDATA, bus.RRESP, bus.RLAST}, rq[0]);
        end
        if (bus.BVALID && bus.BREADY) begin
            if (bq.size() == 0) fail("b_unexpected");
            else chk("bresp", bus.BRESP, bq.pop_front());
        end
    end

    task automatic hs(input string name, input int sel);
        int t = 0;
        @(negedge clk);
        while (!(sel == 0 ? bus.AWREADY : sel == 1 ? bus.WREADY : bus.ARREADY) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) fail({name, "_timeout"});
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [15:0] a, input logic [7:0] len, input logic [1:0] burst);
        bus.AWADDR = a; bus.AWLEN = len; bus.AWSIZE = 3'd2; bus.AWBURST = burst; bus.AWVALID = 1'b1;
        hs("aw", 0);
        bus.AWVALID = 1'b0;
        chk("aw_to_wready", bus.WREADY, 1);
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic last);
        bus.WDATA = d; bus.WSTRB = s; bus.WLAST = last; bus.WVALID = 1'b1;
        hs("w", 1);
        bus.WVALID = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] len, input logic [31:0] d0,
                      input logic [3:0] s, input logic [1:0] resp);
        bq.push_back(resp);
        aw(a, len, 2'd1);
        for (int i = 0; i <= int'(len); i++) wbeat(d0 + 32'(i), s, i == int'(len));
        chk("w_to_bvalid", bus.BVALID, 1);
    endtask

    task automatic ar(input logic [15:0] a, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        bus.ARADDR = a; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst; bus.ARVALID = 1'b1;
        hs("ar", 2);
        bus.ARVALID = 1'b0;
        chk("ar_to_rvalid", bus.RVALID, 1);
    endtask

    task automatic er(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rq.push_back({d, resp, last});
    endtask

    task automatic drain();
        int t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (t == 200) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {bus.AWREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.ARREADY,
                bus.RVALID, bus.RLAST, bus.RRESP, bus.RDATA};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0; bus.WLAST = 0;
        bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0;
        bus.WDATA = 0; bus.WSTRB = 0; bus.ARADDR = 0; bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0;
        bus.BREADY = 1; bus.RREADY = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {bus.AWREADY, bus.ARREADY}, 2'b11);

        wr(16'h0010, 8'd3, 32'hA0, 4'hF, 2'd0);
        drain();
        for (int i = 0; i < 4; i++) er(32'hA0 + 32'(i), 2'd0, i == 3);
        ar(16'h0010, 8'd3, 3'd2, 2'd1);
        drain();

        wr(16'h0020, 8'd0, 32'h11223344, 4'hF, 2'd0);
        wr(16'h0020, 8'd0, 32'hAABBCCDD, 4'h5, 2'd0);
        drain();
        er(32'h11BB33DD, 2'd0, 1'b1);
        ar(16'h0020, 8'd0, 3'd2, 2'd1);
        drain();

        wr(16'h0FFC, 8'd1, 32'hC0FFEE00, 4'hF, 2'd2);
        drain();
        er(32'hC0FFEE00, 2'd0, 1'b0);
        er(32'h0, 2'd2, 1'b1);
        ar(16'h0FFC, 8'd1, 3'd2, 2'd1);
        drain();

        wr(16'h0100, 8'd7, 32'hB0, 4'hF, 2'd0);
        drain();
        for (int i = 0; i < 8; i++) er(32'hB0 + 32'(i), 2'd0, i == 7);
        bus.RREADY = 1'b0;
        ar(16'h0100, 8'd7, 3'd2, 2'd1);
        for (int i = 0; rq.size() != 0 && i < 100; i++) begin
            bus.RREADY = (i % 3) == 0;
            @(posedge clk);
            #1;
        end
        bus.RREADY = 1'b1;
        drain();

        bus.BREADY = 1'b0;
        wr(16'h0200, 8'd0, 32'h5A5A5A5A, 4'hF, 2'd0);
        for (int i = 0; i < 5; i++) begin
            chk("b_hold", {bus.BVALID, bus.BRESP}, 3'b100);
            @(posedge clk);
            #1;
        end
        bus.BREADY = 1'b1;
        drain();

        wr(16'h0030, 8'd3, 32'hD0, 4'hF, 2'd0);
        drain();
`ifdef AXI4_MEM_WRAP_BURST_EN
        er(32'hD2, 2'd0, 1'b0); er(32'hD3, 2'd0, 1'b0); er(32'hD0, 2'd0, 1'b0); er(32'hD1, 2'd0, 1'b1);
`else
        for (int i = 0; i < 4; i++) er(32'h0, 2'd2, i == 3);
`endif
        ar(16'h0038, 8'd3, 3'd2, 2'd2);
        drain();

        er(32'h0, 2'd2, 1'b1);
        ar(16'h0010, 8'd0, 3'd2, 2'd3);
        drain();
        er(32'h0, 2'd2, 1'b1);
        ar(16'h0010, 8'd0, 3'd3, 2'd1);
        drain();

        aw(16'h0300, 8'd7, 2'd1);
        wbeat(32'hE0, 4'hF, 1'b0);
        wbeat(32'hE1, 4'hF, 1'b0);
        bus.WDATA = 32'hE2; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_burst", outs(), 0);
        rst = 1'b0;
        bus.WVALID = 1'b0;
        @(posedge clk);
        #1;
        wr(16'h0400, 8'd0, 32'h77, 4'hF, 2'd0);
        drain();
        er(32'hE0, 2'd0, 1'b0);
        er(32'hE1, 2'd0, 1'b1);
        ar(16'h0300, 8'd1, 3'd2, 2'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
